// File: rtl/cmp_pkg.sv
// Shared types and constants for the shared compare engine (cmp_share_ctrl).
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_BR  = 1'b1;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned CHUNK_DEF = 8;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare.
module cmp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/cmp_share_ctrl.sv
// Two-requester round-robin arbiter around a chunked MSB-first comparator.
// Define CMP_EARLY_EXIT_EN to stop on the first differing chunk; otherwise constant-time.
module cmp_share_ctrl
    import cmp_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CHUNK = CHUNK_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req0_signed,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic            req1_signed,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic            rsp_lt,
    output logic            rsp_eq,
    output logic [XLEN-1:0] rsp_result
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
`ifndef CMP_EARLY_EXIT_EN
    logic            found_q, found_d;
`endif

    logic            grant0, grant1, idle;
    logic [XLEN-1:0] acc_rs1, acc_rs2;
    logic            acc_signed;
    logic            chunk_lt, chunk_eq;

    assign idle   = (state_q == IDLE);
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready = idle & grant0 & ~flush;
    assign req1_ready = idle & grant1 & ~flush;

    assign acc_rs1    = grant1 ? req1_rs1    : req0_rs1;
    assign acc_rs2    = grant1 ? req1_rs2    : req0_rs2;
    assign acc_signed = grant1 ? req1_signed : req0_signed;

    // Operands shift left each SCAN cycle so the active chunk is always the top one.
    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (a_q[XLEN-1 -: CHUNK]),
        .b_i  (b_q[XLEN-1 -: CHUNK]),
        .lt_o (chunk_lt),
        .eq_o (chunk_eq)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        last_d  = last_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
`ifndef CMP_EARLY_EXIT_EN
        found_d = found_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    // Signed compare: flipping both MSBs maps two's complement onto unsigned order.
                    a_d     = {acc_rs1[XLEN-1] ^ acc_signed, acc_rs1[XLEN-2:0]};
                    b_d     = {acc_rs2[XLEN-1] ^ acc_signed, acc_rs2[XLEN-2:0]};
                    id_d    = grant1 ? REQ_BR : REQ_ALU;
                    last_d  = grant1;
                    idx_d   = IDX_LAST;
`ifndef CMP_EARLY_EXIT_EN
                    found_d = 1'b0;
`endif
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    a_d = a_q << CHUNK;
                    b_d = b_q << CHUNK;
`ifdef CMP_EARLY_EXIT_EN
                    lt_d = chunk_lt;
                    eq_d = chunk_eq;
                    if (!chunk_eq || idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
`else
                    if (!found_q) begin
                        lt_d    = chunk_lt;
                        eq_d    = chunk_eq;
                        found_d = ~chunk_eq;
                    end
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            found_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            last_q  <= last_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
`ifndef CMP_EARLY_EXIT_EN
            found_q <= found_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = id_q;
    assign rsp_lt     = lt_q;
    assign rsp_eq     = eq_q;
    assign rsp_result = {{(XLEN-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Scoreboard bench for cmp_share_ctrl: directed cases plus randomized traffic.
module tb_cmp_share_ctrl;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = XLEN / CHUNK;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, flush;
    logic            req0_valid, req0_ready, req0_signed;
    logic            req1_valid, req1_ready, req1_signed;
    logic [XLEN-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_lt, rsp_eq;
    logic [XLEN-1:0] rsp_result;

    cmp_share_ctrl #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_signed(req0_signed),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_signed(req1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_result(rsp_result)
    );

    typedef struct {
        logic        id;
        logic        lt;
        logic        eq;
        int unsigned first;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, idle_from = 0, n_acc = 0;
    logic        m_last = 1'b1;
    logic        prev_valid = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain signed/unsigned compare; latency from the first differing chunk.
    function automatic exp_t model(logic id, logic [63:0] rs1, logic [63:0] rs2,
                                   logic sgn, int unsigned acc_cyc);
        exp_t        e;
        logic [63:0] d;
        int unsigned k;
        e.id = id;
        e.eq = (rs1 == rs2);
        e.lt = sgn ? ($signed(rs1) < $signed(rs2)) : (rs1 < rs2);
        d = rs1 ^ rs2;
        k = NCHUNK;
        for (int unsigned i = 0; i < NCHUNK; i++)
            if (((d >> (i * CHUNK)) & ((64'd1 << CHUNK) - 1)) != 0) k = NCHUNK - i;
`ifndef CMP_EARLY_EXIT_EN
        k = NCHUNK;
`endif
        e.first = acc_cyc + 1 + k;
        return e;
    endfunction

    // Request side: predict ready, push expectations on accept, drop on flush.
    always @(negedge clk) begin
        logic idle, g0, g1;
        if (rst_n && chk_en) begin
            idle = (sb.size() == 0) && (cyc >= idle_from);
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, idle && g0 && !flush);
            chk("req1_ready", req1_ready, idle && g1 && !flush);
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_rs1, req0_rs2, req0_signed, cyc));
                m_last = 1'b0;
                n_acc++;
            end else if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_rs1, req1_rs2, req1_signed, cyc));
                m_last = 1'b1;
                n_acc++;
            end else if (flush && sb.size() != 0) begin
                sb.delete(0);
                idle_from = cyc + 1;
            end
        end
    end

    // Response side: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (sb.size() != 0 && cyc == sb[0].first) chk("valid_on_time", rsp_valid, 1);
            if (rsp_valid && !flush) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", rsp_valid, 0);
                end else begin
                    if (!prev_valid) chk("latency", cyc, sb[0].first);
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_lt", rsp_lt, sb[0].lt);
                    chk("rsp_eq", rsp_eq, sb[0].eq);
                    chk("rsp_result", rsp_result, 64'(sb[0].lt));
                    if (rsp_ready) begin
                        sb.delete(0);
                        idle_from = cyc + 1;
                    end
                end
            end
            prev_valid = rsp_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic gen_pair(output logic [63:0] a, output logic [63:0] b);
        logic [63:0] corner [5];
        logic [63:0] ones, m;
        int unsigned p;
        corner = '{64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, '1};
        ones = '1;
        a = rnd64();
        case ($urandom_range(0, 3))
            0: b = a;
            1: begin
                p = $urandom_range(0, NCHUNK - 1);
                m = (p == NCHUNK - 1) ? 64'h0 : (ones << ((p + 1) * CHUNK));
                b = (a & m) | (rnd64() & ~m);
            end
            2: b = rnd64();
            default: begin
                a = corner[$urandom_range(0, 4)];
                b = corner[$urandom_range(0, 4)];
            end
        endcase
    endtask

    task automatic issue(int port, logic [63:0] a, logic [63:0] b, logic s);
        int unsigned start;
        start = n_acc;
        if (port == 0) begin
            req0_valid = 1'b1; req0_rs1 = a; req0_rs2 = b; req0_signed = s;
        end else begin
            req1_valid = 1'b1; req1_rs1 = a; req1_rs2 = b; req1_signed = s;
        end
        for (int i = 0; i < 60 && n_acc == start; i++) step();
        chk("accept_seen", n_acc - start, 1);
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_accept(int unsigned start, int unsigned cnt, int unsigned budget, string name);
        for (int unsigned i = 0; i < budget && n_acc - start < cnt; i++) step();
        chk(name, n_acc - start, cnt);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 80 && sb.size() != 0; i++) step();
        chk("drain", sb.size(), 0);
        step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_lt", rsp_lt, 0);
        chk("rst_rsp_eq", rsp_eq, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        m_last = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        idle_from = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_rs1 = '0; req0_rs2 = '0; req0_signed = 1'b0;
        req1_valid = 1'b0; req1_rs1 = '0; req1_rs2 = '0; req1_signed = 1'b0;
        repeat (3) step();
        check_reset_outputs();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        issue(0, 64'h8000_0000_0000_0000, 64'h0, 1'b0); drain();
        issue(0, 64'h8000_0000_0000_0000, 64'h0, 1'b1); drain();
        issue(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0); drain();
        issue(1, 64'h1, 64'h2, 1'b0); drain();

        // Round-robin from reset with both requesters always valid.
        do_reset();
        s = n_acc;
        req0_valid = 1'b1; req0_rs1 = 64'h5; req0_rs2 = 64'h5_0000; req0_signed = 1'b0;
        req1_valid = 1'b1; req1_rs1 = '1;    req1_rs2 = 64'h3;      req1_signed = 1'b1;
        wait_accept(s, 4, 200, "rr_grants");
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Back-pressure in DONE with a pending requester.
        rsp_ready = 1'b0;
        issue(0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0);
        req1_valid = 1'b1; req1_rs1 = 64'h10; req1_rs2 = 64'h20; req1_signed = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) step();
        repeat (3) step();
        s = n_acc;
        rsp_ready = 1'b1;
        wait_accept(s, 1, 20, "bp_next_accept");
        req1_valid = 1'b0;
        drain();

        // Flush mid-scan with a pending requester.
        issue(0, 64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678, 1'b0);
        req1_valid = 1'b1; req1_rs1 = 64'h7; req1_rs2 = 64'h7; req1_signed = 1'b1;
        repeat (3) step();
        s = n_acc;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_accept(s, 1, 20, "flush_next_accept");
        req1_valid = 1'b0;
        drain();

        for (int i = 0; i < 800; i++) begin
            req0_valid  = ($urandom_range(0, 9) < 6);
            req1_valid  = ($urandom_range(0, 9) < 6);
            req0_signed = $urandom_range(0, 1) != 0;
            req1_signed = $urandom_range(0, 1) != 0;
            gen_pair(req0_rs1, req0_rs2);
            gen_pair(req1_rs1, req1_rs2);
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 4);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        drain();

        // Asynchronous reset in the middle of a scan.
        issue(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (3) step();
        do_reset();
        issue(0, 64'h1, 64'h2, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmp_share_ctrl.md
Name: cmp_share_ctrl

Overview:
- Shared multi-cycle compare engine and arbiter for the pipelined core.
- Two requesters share one chunked comparator: ALU SLT/SLTU (req0) and the branch unit BLT/BLTU/BEQ (req1).
- Operands are scanned MSB-chunk first, CHUNK bits per cycle, with early termination on the first differing chunk.
- Returns lt/eq and an XLEN-wide SLT-style result (lt zero-extended).

Parameters:
- XLEN, 64, operand width.
- CHUNK, 8, bits compared per cycle; XLEN % CHUNK must be 0.
- NCHUNK (derived), XLEN/CHUNK.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  abort the in-flight op; no response is produced.
- req0_valid / req1_valid  in  1  request valid.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_rs1, req0_rs2, req1_rs1, req1_rs2  in  XLEN  operands.
- req0_signed / req1_signed  in  1  1 = signed compare, 0 = unsigned.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  requester index of the result.
- rsp_lt  out  1  rs1 < rs2.
- rsp_eq  out  1  rs1 == rs2.
- rsp_result  out  XLEN  {XLEN-1 zeros, rsp_lt}.

Behaviour:
- Reset: all outputs 0; state IDLE; chunk index 0; last_grant = 1, so req0 wins the first tie.
- FSM states: IDLE, SCAN, DONE.
- IDLE, arbitration:
  - Round-robin between the valid requesters; the requester not granted last time wins a tie.
  - reqN_ready = (state==IDLE) & grantN & !flush. Ready depends combinationally on valid.
  - On accept: latch rs1, rs2, signed and id; set idx = NCHUNK-1; update last_grant; go to SCAN.
- Signed mode: the MSB of both latched operands is inverted at latch time (bias). The chunk compare is then always unsigned.
- SCAN, each cycle:
  - Compare chunk idx of a and b.
  - If they differ: lt = (a_chunk < b_chunk), eq = 0, go to DONE.
  - Else if idx == 0: lt = 0, eq = 1, go to DONE.
  - Else idx decrements.
- DONE:
  - rsp_valid = 1; rsp_id, rsp_lt, rsp_eq and rsp_result are registered and held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE. A new request can be accepted the following cycle.
  - No accept is possible while in SCAN or DONE.
- Latency: accept at cycle T.
  - Result is deciding chunk k (1..NCHUNK) at T+k; rsp_valid is high from T+k+1.
  - Minimum 2 cycles, maximum NCHUNK+1.
- Flush:
  - In SCAN or DONE: return to IDLE next cycle; rsp_valid drops; the result is discarded.
  - In IDLE: blocks accept that cycle.
  - Flush has priority over a simultaneous rsp_ready.
- Reset asserted mid-operation clears all state immediately (asynchronous); no response is produced.
- Operands held by a requester after accept are don't-care.

Optional Feature:
- CMP_EARLY_EXIT_EN
- Defined: early termination as described above; latency is data-dependent.
- Undefined: SCAN always runs all NCHUNK chunks.
  - The first differing chunk is recorded by a sticky found flag; later chunks do not change lt/eq.
  - Fixed latency of NCHUNK+1 cycles (constant-time).

Decomposition:
- Package cmp_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - requester ID constants REQ_ALU = 0, REQ_BR = 1;
  - defaults XLEN_DEF = 64, CHUNK_DEF = 8.
- One sub-module, cmp_chunk: combinational CHUNK-bit unsigned compare, outputs lt and eq.
- cmp_share_ctrl holds the arbiter, FSM, operand registers and response registers.

Test Plan (XLEN=64, CHUNK=8, CMP_EARLY_EXIT_EN defined):
- Unsigned MSB case: req0, signed=0, rs1=0x8000_0000_0000_0000, rs2=0 -> rsp_lt=0, rsp_eq=0, rsp_id=0, rsp_valid 2 cycles after accept. Same with signed=1 -> rsp_lt=1, rsp_result=1.
- Equal and LSB-only cases: req1, rs1=rs2=0x1234_5678_9ABC_DEF0 -> rsp_eq=1, rsp_lt=0, latency 9. rs1=1, rs2=2 unsigned -> rsp_lt=1, latency 9.
- Round-robin: both valid every cycle from reset -> grants in order req0, req1, req0, req1; each ready pulse is 1 cycle, and never both in the same cycle.
- Back-pressure: rsp_ready low for 3 cycles in DONE -> outputs stable, both ready signals 0; rsp_ready high -> next accept one cycle later.
- Flush mid-SCAN at chunk 4 -> no rsp_valid, IDLE next cycle, pending req accepted the following cycle. rst_n pulsed mid-SCAN -> all outputs 0 at once.
- With CMP_EARLY_EXIT_EN undefined: rs1=0x8000_0000_0000_0000, rs2=0 unsigned -> rsp_lt=0, latency 9.
